life_gen_sequencer: RTL

- Generation scheduler for the Game-of-Life row datapath. Owns a single-read, single-write row memory split into two banks (ping-pong).
- For each row r it fetches rows r-1, r and r+1 (toroidal wrap) and drives them onto rd1/rd2/rd3 for the combinational next-row logic. It captures new_r and writes it to the inactive bank. At the end of a generation it flips banks.
- Also arbitrates host load/readback access to the memory against generation compute.

---
 rtl/life_pkg.sv | 20 ++
 rtl/life_row_ptr.sv | 35 +++
 rtl/life_gen_sequencer.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/life_pkg.sv
// Shared types and defaults for the Game-of-Life generation sequencer.
// Contents: default board geometry, sequencer state encoding, and the
// generation counter width.
package life_pkg;

    localparam int unsigned ROWS_DEF  = 8;
    localparam int unsigned ROW_W_DEF = 8;
    localparam int unsigned GEN_CNT_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        RA,
        RC,
        RB,
        CAP,
        WR,
        FLIP
    } seq_state_t;

endpackage

// File: rtl/life_row_ptr.sv
// Row pointer for the generation sequencer.
// Holds the current row index and presents the toroidally wrapped indices
// of the rows above and below it.
// Ports: clk, rst_n (async active-low), clr (row <= 0, wins over inc),
//        inc (row <= row + 1), row / above / below (AW-bit indices).
module life_row_ptr
    import life_pkg::*;
#(
    parameter int unsigned AW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          inc,
    output logic [AW-1:0] row,
    output logic [AW-1:0] above,
    output logic [AW-1:0] below
);

    // Current row register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row <= '0;
        end else if (clr) begin
            row <= '0;
        end else if (inc) begin
            row <= row + AW'(1);
        end
    end

    // Board height is a power of two, so AW-bit wraparound gives the torus
    assign above = row - AW'(1);
    assign below = row + AW'(1);

endmodule

// File: rtl/life_gen_sequencer.sv
// Generation scheduler for the Game-of-Life row datapath.
// Walks the active (read) bank row by row, fetching the rows above, at and
// below each row onto rd1/rd2/rd3, writes the datapath's new_r into the
// inactive bank, and flips banks at the end of each generation. In IDLE it
// also grants host load/readback access to the active bank.
// Ports:
//   ph1, reset        clock (rising edge), async active-low reset
//   start, run        single-generation request / free-run enable
//   busy, gen_done    not-IDLE status, one-cycle pulse in FLIP
//   gen_count, bank   completed generations, active bank
//   mem_*             single-read / single-write row memory interface
//   rd1, rd2, rd3     rows above / current / below to the datapath
//   new_r             next-state row from the datapath
//   host_*            host access request / grant / readback
// Optional build macro LIFE_STILL_DETECT_EN adds output `still`: a generation
// whose every new row equals its old row stops free-running.
module life_gen_sequencer
    import life_pkg::*;
#(
    parameter int unsigned ROWS  = ROWS_DEF,
    parameter int unsigned ROW_W = ROW_W_DEF,
    parameter int unsigned AW    = $clog2(ROWS)
) (
    input  logic                 ph1,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 run,
    output logic                 busy,
    output logic                 gen_done,
    output logic [GEN_CNT_W-1:0] gen_count,
    output logic                 bank,
    output logic                 mem_re,
    output logic [AW:0]          mem_raddr,
    input  logic [ROW_W-1:0]     mem_rdata,
    output logic                 mem_we,
    output logic [AW:0]          mem_waddr,
    output logic [ROW_W-1:0]     mem_wdata,
    output logic [ROW_W-1:0]     rd1,
    output logic [ROW_W-1:0]     rd2,
    output logic [ROW_W-1:0]     rd3,
    input  logic [ROW_W-1:0]     new_r,
    input  logic                 host_req,
    input  logic                 host_wr,
    input  logic [AW-1:0]        host_row,
    input  logic [ROW_W-1:0]     host_wdata,
    output logic                 host_ack,
    output logic [ROW_W-1:0]     host_rdata
`ifdef LIFE_STILL_DETECT_EN
    ,
    output logic                 still
`endif
);

    seq_state_t    state;
    logic [AW-1:0] row;
    logic [AW-1:0] above;
    logic [AW-1:0] below;
    logic          row_clr;
    logic          row_inc;
    logic          last_row;
    logic          host_rd_pend;
`ifdef LIFE_STILL_DETECT_EN
    logic          still_flag;
`endif

    life_row_ptr #(.AW(AW)) u_row_ptr (
        .clk   (ph1),
        .rst_n (reset),
        .clr   (row_clr),
        .inc   (row_inc),
        .row   (row),
        .above (above),
        .below (below)
    );

    assign last_row = (row == AW'(ROWS - 1));
    assign busy     = (state != IDLE);
    assign gen_done = (state == FLIP);

    // Memory strobes, host grant and row pointer control decoded from state
    always_comb begin
        mem_re    = 1'b0;
        mem_raddr = {bank, row};
        mem_we    = 1'b0;
        mem_waddr = {~bank, row};
        mem_wdata = new_r;
        host_ack  = 1'b0;
        row_clr   = 1'b0;
        row_inc   = 1'b0;
        case (state)
            IDLE: begin
                if (host_req) begin
                    host_ack = 1'b1;
                    if (host_wr) begin
                        mem_we    = 1'b1;
                        mem_waddr = {bank, host_row};
                        mem_wdata = host_wdata;
                    end else begin
                        mem_re    = 1'b1;
                        mem_raddr = {bank, host_row};
                    end
                end else if (start || run) begin
                    row_clr = 1'b1;
                end
            end
            RA: begin
                mem_re    = 1'b1;
                mem_raddr = {bank, above};
            end
            RC: begin
                mem_re    = 1'b1;
                mem_raddr = {bank, row};
            end
            RB: begin
                mem_re    = 1'b1;
                mem_raddr = {bank, below};
            end
            WR: begin
                mem_we  = 1'b1;
                row_inc = !last_row;
            end
            FLIP: begin
                row_clr = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Sequencer state, row capture, bank/generation bookkeeping, host readback
    always_ff @(posedge ph1 or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            bank         <= 1'b0;
            gen_count    <= '0;
            rd1          <= '0;
            rd2          <= '0;
            rd3          <= '0;
            host_rd_pend <= 1'b0;
            host_rdata   <= '0;
`ifdef LIFE_STILL_DETECT_EN
            still        <= 1'b0;
            still_flag   <= 1'b1;
`endif
        end else begin
            // Read data returns one cycle after the grant; register it then
            host_rd_pend <= host_ack && !host_wr;
            if (host_rd_pend) begin
                host_rdata <= mem_rdata;
            end
            case (state)
                IDLE: begin
                    if (!host_req && (start || run)) begin
                        state <= RA;
`ifdef LIFE_STILL_DETECT_EN
                        still      <= 1'b0;
                        still_flag <= 1'b1;
`endif
                    end
                end
                RA: state <= RC;
                RC: begin
                    rd1   <= mem_rdata;
                    state <= RB;
                end
                RB: begin
                    rd2   <= mem_rdata;
                    state <= CAP;
                end
                CAP: begin
                    rd3   <= mem_rdata;
                    state <= WR;
                end
                WR: begin
`ifdef LIFE_STILL_DETECT_EN
                    still_flag <= still_flag && (new_r == rd2);
`endif
                    state <= last_row ? FLIP : RA;
                end
                FLIP: begin
                    bank      <= ~bank;
                    gen_count <= gen_count + GEN_CNT_W'(1);
`ifdef LIFE_STILL_DETECT_EN
                    still      <= still_flag;
                    still_flag <= 1'b1;
                    state      <= (run && !still_flag) ? RA : IDLE;
`else
                    state <= run ? RA : IDLE;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
